ex_md_stage: RTL

Parametrised execute stage for the 5-stage pipeline: operand forwarding, ALU execution, branch resolution and the EX/MEM pipeline register. It adds an iterative multiply/divide unit with HI/LO registers that runs alongside the main pipe. Only instructions that depend on HI/LO are stalled while the unit is busy. It sits between the ID/EX register and the MEM stage, and instantiates the existing `ALU` module.

---
 rtl/ex_md_stage_if.sv | 28 ++
 rtl/ex_md_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_md_stage_if.sv
// EX/MEM output bundle for ex_md_stage.
// The master drives the registered EX/MEM fields and receives the downstream stall.
interface ex_md_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              stall_in;
   logic              out_valid;
   logic              out_regwrite;
   logic              out_memread;
   logic              out_memwrite;
   logic [DATA_W-1:0] out_result;
   logic [DATA_W-1:0] out_wdata;
   logic [REG_AW-1:0] out_waddr;
   logic [DATA_W-1:0] out_pc4;

   modport master (
      input  stall_in,
      output out_valid, out_regwrite, out_memread, out_memwrite,
      output out_result, out_wdata, out_waddr, out_pc4
   );

   modport slave (
      output stall_in,
      input  out_valid, out_regwrite, out_memread, out_memwrite,
      input  out_result, out_wdata, out_waddr, out_pc4
   );
endinterface

// File: rtl/ex_md_stage.sv
// Execute stage: forwarding, ALU, branch resolution, EX/MEM register and an
// iterative multiply/divide unit with HI/LO that runs beside the main pipe.
// Optional macro EX_FAST_MUL_EN: MULT becomes a single-cycle multiplier.
module ALU #(
   parameter int DATA_W = 32,
   parameter int SH_W   = $clog2(DATA_W)
) (
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [5:0]        ALUFun,
   input  logic              Sign,
   output logic [DATA_W-1:0] S
);
   logic [SH_W-1:0] sh;
   logic            lt, a_neg, a_zero, cmp;

   assign sh     = A[SH_W-1:0];
   assign a_neg  = A[DATA_W-1];
   assign a_zero = (A == '0);
   assign lt     = Sign ? ($signed(A) < $signed(B)) : (A < B);

   // Function-group decode: arithmetic, logic, shift (B by A), compare.
   always_comb begin
      cmp = 1'b0;
      case (ALUFun[3:1])
         3'b001:  cmp = (A == B);
         3'b000:  cmp = (A != B);
         3'b010:  cmp = lt;
         3'b110:  cmp = a_neg | a_zero;
         3'b101:  cmp = a_neg;
         3'b111:  cmp = ~a_neg & ~a_zero;
         default: cmp = 1'b0;
      endcase
      S = '0;
      case (ALUFun[5:4])
         2'b00: S = ALUFun[0] ? (A - B) : (A + B);
         2'b01: begin
            case (ALUFun[3:0])
               4'b1000: S = A & B;
               4'b1110: S = A | B;
               4'b0110: S = A ^ B;
               4'b0001: S = ~(A | B);
               4'b1010: S = A;
               default: S = '0;
            endcase
         end
         2'b10: begin
            case (ALUFun[1:0])
               2'b00:   S = B << sh;
               2'b01:   S = B >> sh;
               2'b11:   S = $signed(B) >>> sh;
               default: S = '0;
            endcase
         end
         default: S = {{(DATA_W-1){1'b0}}, cmp};
      endcase
   end
endmodule

module ex_md_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int SH_W   = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              in_valid,
   input  logic [REG_AW-1:0] Rs, Rt, Rd,
   input  logic [DATA_W-1:0] RsData, RtData,
   input  logic [SH_W-1:0]   Shamt,
   input  logic [DATA_W-1:0] Imm,
   input  logic              ALUSrc1, ALUSrc2,
   input  logic [5:0]        ALUFun,
   input  logic              Sign,
   input  logic [2:0]        MDOp,
   input  logic              Branch, MemRead, MemWrite, RegWrite,
   input  logic [1:0]        RegDst,
   input  logic [DATA_W-1:0] PC_Plus4,
   input  logic [REG_AW-1:0] EX_MEM_Rd, MEM_WB_Rd,
   input  logic [DATA_W-1:0] EX_MEM_RdData, MEM_WB_RdData,
   input  logic              EX_MEM_RegWrite, MEM_WB_RegWrite,
   output logic              PCSrcB,
   output logic              ex_busy,
   ex_md_stage_if.master     exm
);
   localparam int CW = $clog2(DATA_W);
   localparam logic [2:0] MD_MULT = 3'd1, MD_DIV = 3'd2, MD_MFHI = 3'd3,
                          MD_MFLO = 3'd4, MD_MTHI = 3'd5, MD_MTLO = 3'd6;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;

   md_state_t           state;
   logic [CW-1:0]       cnt;
   logic [DATA_W-1:0]   hi, lo;
   logic [DATA_W-1:0]   acc;      // product high half / partial remainder
   logic [DATA_W-1:0]   mq;       // multiplier shifting out / quotient shifting in
   logic [DATA_W-1:0]   dvs;      // multiplicand / divisor magnitude
   logic                neg_q, neg_r, div_zero, md_div;

   logic [DATA_W-1:0]   fwd_rs, fwd_rt, alu_a, alu_b, alu_s, mag_a, mag_b, result;
   logic [REG_AW-1:0]   waddr;
   logic                sgn_q, md_go;
   logic [DATA_W:0]     mul_sum, div_shift, div_diff;
   logic [2*DATA_W-1:0] prod_fix;

   // EX/MEM has priority over MEM/WB; register 0 is never forwarded.
   function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] r,
                                             input logic [DATA_W-1:0] rf);
      if (EX_MEM_RegWrite && EX_MEM_Rd != '0 && EX_MEM_Rd == r) return EX_MEM_RdData;
      if (MEM_WB_RegWrite && MEM_WB_Rd != '0 && MEM_WB_Rd == r) return MEM_WB_RdData;
      return rf;
   endfunction

   assign fwd_rs = fwd(Rs, RsData);
   assign fwd_rt = fwd(Rt, RtData);
   assign alu_a  = ALUSrc1 ? {{(DATA_W-SH_W){1'b0}}, Shamt} : fwd_rs;
   assign alu_b  = ALUSrc2 ? Imm : fwd_rt;

   ALU #(.DATA_W(DATA_W), .SH_W(SH_W)) u_alu (
      .A(alu_a), .B(alu_b), .ALUFun(ALUFun), .Sign(Sign), .S(alu_s)
   );

   assign PCSrcB  = in_valid & Branch & alu_s[0];
   assign ex_busy = in_valid & (state != IDLE) & (MDOp != 3'd0);
   assign md_go   = in_valid & ~exm.stall_in & ~ex_busy & (state == IDLE);

   assign mag_a = (Sign && fwd_rs[DATA_W-1]) ? -fwd_rs : fwd_rs;
   assign mag_b = (Sign && fwd_rt[DATA_W-1]) ? -fwd_rt : fwd_rt;
   assign sgn_q = Sign & (fwd_rs[DATA_W-1] ^ fwd_rt[DATA_W-1]);

   // One shift-add or restoring shift-subtract step; divide-by-zero never subtracts
   // so the dividend magnitude ends up in acc untouched.
   assign mul_sum   = {1'b0, acc} + {1'b0, (mq[0] ? dvs : {DATA_W{1'b0}})};
   assign div_shift = {acc, mq[DATA_W-1]};
   assign div_diff  = div_shift - {1'b0, dvs};
   assign prod_fix  = neg_q ? -{acc, mq} : {acc, mq};

`ifdef EX_FAST_MUL_EN
   logic [2*DATA_W-1:0] fast_mag, fast_prod;
   assign fast_mag  = {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
   assign fast_prod = sgn_q ? -fast_mag : fast_mag;
`endif

   assign result = (MDOp == MD_MFHI) ? hi : (MDOp == MD_MFLO) ? lo : alu_s;

   always_comb begin
      case (RegDst)
         2'd0:    waddr = Rd;
         2'd1:    waddr = Rt;
         2'd2:    waddr = REG_AW'(31);
         default: waddr = REG_AW'(26);
      endcase
   end

   // MD state machine plus HI/LO, including direct MTHI/MTLO writes on acceptance.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state <= IDLE;   cnt <= '0;    hi <= '0;       lo <= '0;
         acc <= '0;       mq <= '0;     dvs <= '0;
         neg_q <= 1'b0;   neg_r <= 1'b0; div_zero <= 1'b0; md_div <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (md_go && (MDOp == MD_MULT || MDOp == MD_DIV)) begin
                  acc      <= '0;
                  mq       <= mag_a;
                  dvs      <= mag_b;
                  neg_q    <= sgn_q;
                  neg_r    <= Sign & fwd_rs[DATA_W-1];
                  div_zero <= (fwd_rt == '0);
                  md_div   <= (MDOp == MD_DIV);
                  cnt      <= '0;
               end
               if (md_go) begin
                  case (MDOp)
`ifdef EX_FAST_MUL_EN
                     MD_MULT: begin
                        hi <= fast_prod[2*DATA_W-1:DATA_W];
                        lo <= fast_prod[DATA_W-1:0];
                     end
`else
                     MD_MULT: state <= MUL;
`endif
                     MD_DIV:  state <= DIV;
                     MD_MTHI: hi <= fwd_rs;
                     MD_MTLO: lo <= fwd_rs;
                     default: ;
                  endcase
               end
            end
            MUL: begin
               acc <= mul_sum[DATA_W:1];
               mq  <= {mul_sum[0], mq[DATA_W-1:1]};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(DATA_W-1)) state <= FIX;
            end
            DIV: begin
               if (!div_diff[DATA_W] && !div_zero) begin
                  acc <= div_diff[DATA_W-1:0];
                  mq  <= {mq[DATA_W-2:0], 1'b1};
               end else begin
                  acc <= div_shift[DATA_W-1:0];
                  mq  <= {mq[DATA_W-2:0], 1'b0};
               end
               cnt <= cnt + CW'(1);
               if (cnt == CW'(DATA_W-1)) state <= FIX;
            end
            default: begin
               if (md_div) begin
                  hi <= neg_r ? -acc : acc;
                  lo <= div_zero ? {DATA_W{1'b1}} : (neg_q ? -mq : mq);
               end else begin
                  hi <= prod_fix[2*DATA_W-1:DATA_W];
                  lo <= prod_fix[DATA_W-1:0];
               end
               state <= IDLE;
            end
         endcase
      end
   end

   // EX/MEM register: downstream stall holds, HI/LO hazard inserts a bubble.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         exm.out_valid <= 1'b0;  exm.out_regwrite <= 1'b0;
         exm.out_memread <= 1'b0; exm.out_memwrite <= 1'b0;
         exm.out_result <= '0;   exm.out_wdata <= '0;
         exm.out_waddr <= '0;    exm.out_pc4 <= '0;
      end else if (!exm.stall_in) begin
         if (ex_busy) begin
            exm.out_valid    <= 1'b0;
            exm.out_regwrite <= 1'b0;
            exm.out_memread  <= 1'b0;
            exm.out_memwrite <= 1'b0;
         end else begin
            exm.out_valid    <= in_valid;
            exm.out_regwrite <= in_valid & RegWrite;
            exm.out_memread  <= in_valid & MemRead;
            exm.out_memwrite <= in_valid & MemWrite;
            exm.out_result   <= result;
            exm.out_wdata    <= fwd_rt;
            exm.out_waddr    <= waddr;
            exm.out_pc4      <= PC_Plus4;
         end
      end
   end
endmodule
